// File: rtl/timer_pkg.sv
// Shared types for the mm:ss countdown timer.
// Digit type, tens/ones limits and FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t TENS_MAX = 4'd5;
  localparam bcd_t ONES_MAX = 4'd9;

  function automatic logic bcd_ok(
    input bcd_t d,
    input bcd_t max
  );
    return d <= max;
  endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// One stage of the BCD borrow chain.
// Wraps 0 to MAX and raises borrow_out on the wrap.
module bcd_dec_digit
  import timer_pkg::*;
#(
  parameter bcd_t MAX = ONES_MAX
) (
  input  bcd_t digit,
  input  logic dec,
  input  logic borrow_in,
  output bcd_t next_digit,
  output logic borrow_out
);

  logic hit;
  logic wrap;

  assign hit  = dec & borrow_in;
  assign wrap = (digit == 4'd0);

  assign borrow_out = hit & wrap;

  // Step down by one, wrapping to MAX on borrow.
  always_comb begin
    next_digit = digit;
    if (hit) begin
      next_digit = wrap ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/cnt_down_timer.sv
// BCD mm:ss countdown timer with done pulse
// and a tick-timed alarm level at 00:00.
module cnt_down_timer
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mo,
  input  logic [3:0] set_st,
  input  logic [3:0] set_so,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [7:0] LIM = 8'(ALARM_TICKS);

  state_t     state;
  logic [7:0] acnt;
  bcd_t       mt, mo, st, so;
  bcd_t       mt_n, mo_n, st_n, so_n;
  logic       b_so, b_st, b_mo, b_mt;
  logic       zero;
  logic       zero_n;
  logic       dec_en;
  logic       valid;

  assign zero = (mt == 4'd0) && (mo == 4'd0)
             && (st == 4'd0) && (so == 4'd0);

  assign zero_n = (mt_n == 4'd0) && (mo_n == 4'd0)
               && (st_n == 4'd0) && (so_n == 4'd0);

  assign dec_en = (state == RUN) && !zero;

  assign valid = bcd_ok(set_mt, TENS_MAX)
              && bcd_ok(set_mo, ONES_MAX)
              && bcd_ok(set_st, TENS_MAX)
              && bcd_ok(set_so, ONES_MAX);

  bcd_dec_digit #(.MAX(ONES_MAX)) u_so (
    .digit      (so),
    .dec        (dec_en),
    .borrow_in  (1'b1),
    .next_digit (so_n),
    .borrow_out (b_so)
  );

  bcd_dec_digit #(.MAX(TENS_MAX)) u_st (
    .digit      (st),
    .dec        (dec_en),
    .borrow_in  (b_so),
    .next_digit (st_n),
    .borrow_out (b_st)
  );

  bcd_dec_digit #(.MAX(ONES_MAX)) u_mo (
    .digit      (mo),
    .dec        (dec_en),
    .borrow_in  (b_st),
    .next_digit (mo_n),
    .borrow_out (b_mo)
  );

  bcd_dec_digit #(.MAX(TENS_MAX)) u_mt (
    .digit      (mt),
    .dec        (dec_en),
    .borrow_in  (b_mo),
    .next_digit (mt_n),
    .borrow_out (b_mt)
  );

  // Prioritised control: load, stop, start, tick.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acnt     <= 8'd0;
      mt       <= 4'd0;
      mo       <= 4'd0;
      st       <= 4'd0;
      so       <= 4'd0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load && valid) begin
        mt    <= set_mt;
        mo    <= set_mo;
        st    <= set_st;
        so    <= set_so;
        state <= IDLE;
        acnt  <= 8'd0;
      end else begin
        load_err <= load;
        if (stop) begin
          if (state == RUN) begin
            state <= PAUSE;
          end else if (state == EXPIRED) begin
            state <= IDLE;
            acnt  <= 8'd0;
          end
        end else if (start) begin
          if ((state == IDLE && !zero)
              || state == PAUSE) begin
            state <= RUN;
          end
        end else if (tick) begin
          if (dec_en) begin
            mt <= mt_n;
            mo <= mo_n;
            st <= st_n;
            so <= so_n;
            if (zero_n) begin
              state <= EXPIRED;
              done  <= 1'b1;
            end
          end else if (state == EXPIRED) begin
            if (acnt + 8'd1 >= LIM) begin
              state <= IDLE;
              acnt  <= 8'd0;
            end else begin
              acnt <= acnt + 8'd1;
            end
          end
        end
      end
    end
  end

  assign min_t   = mt;
  assign min_o   = mo;
  assign sec_t   = st;
  assign sec_o   = so;
  assign running = (state == RUN);
  assign alarm   = (state == EXPIRED);

endmodule

// File: tb/tb_cnt_down_timer.sv
// Directed plus random bench for cnt_down_timer.
// Reference model counts whole seconds.
module tb_cnt_down_timer;

  localparam int AT = 3;

  logic       in_clk;
  logic       rst;
  logic       tick, load, start, stop;
  logic [3:0] set_mt, set_mo, set_st, set_so;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, done, alarm, load_err;

  int vectors;
  int miscompares;

  int secs;
  int mode;
  int acnt;
  bit m_done;
  bit m_lerr;

  cnt_down_timer #(.ALARM_TICKS(AT)) dut (
    .in_clk   (in_clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .start    (start),
    .stop     (stop),
    .set_mt   (set_mt),
    .set_mo   (set_mo),
    .set_st   (set_st),
    .set_so   (set_so),
    .min_t    (min_t),
    .min_o    (min_o),
    .sec_t    (sec_t),
    .sec_o    (sec_o),
    .running  (running),
    .done     (done),
    .alarm    (alarm),
    .load_err (load_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h",
             tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_digits();
    int mm;
    int ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_reset();
    secs   = 0;
    mode   = 0;
    acnt   = 0;
    m_done = 0;
    m_lerr = 0;
  endtask

  // mode: 0 idle, 1 run, 2 pause, 3 expired
  task automatic model_step();
    bit ok;
    m_done = 0;
    m_lerr = 0;
    ok = set_mt <= 5 && set_mo <= 9
      && set_st <= 5 && set_so <= 9;
    if (load && ok) begin
      secs = (set_mt * 10 + set_mo) * 60
           + set_st * 10 + set_so;
      mode = 0;
      acnt = 0;
    end else begin
      m_lerr = load;
      if (stop) begin
        if (mode == 1) mode = 2;
        else if (mode == 3) begin
          mode = 0;
          acnt = 0;
        end
      end else if (start) begin
        if (mode == 2) mode = 1;
        else if (mode == 0 && secs != 0) mode = 1;
      end else if (tick) begin
        if (mode == 1) begin
          secs--;
          if (secs == 0) begin
            mode   = 3;
            m_done = 1;
          end
        end else if (mode == 3) begin
          acnt++;
          if (acnt == AT) begin
            mode = 0;
            acnt = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("digits", {min_t, min_o, sec_t, sec_o},
        exp_digits());
    chk("running", 16'(running), 16'(mode == 1));
    chk("done", 16'(done), 16'(m_done));
    chk("alarm", 16'(alarm), 16'(mode == 3));
    chk("load_err", 16'(load_err), 16'(m_lerr));
  endtask

  task automatic step(
    input bit         ld,
    input bit         sp,
    input bit         sa,
    input bit         tk,
    input logic [3:0] pmt = 4'd0,
    input logic [3:0] pmo = 4'd0,
    input logic [3:0] pst = 4'd0,
    input logic [3:0] pso = 4'd0
  );
    @(negedge in_clk);
    load   = ld;
    stop   = sp;
    start  = sa;
    tick   = tk;
    set_mt = pmt;
    set_mo = pmo;
    set_st = pst;
    set_so = pso;
    @(posedge in_clk);
    model_step();
    #1;
    check_all();
    @(negedge in_clk);
    load  = 0;
    stop  = 0;
    start = 0;
    tick  = 0;
  endtask

  task automatic do_load(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c,
    input logic [3:0] d
  );
    step(1, 0, 0, 0, a, b, c, d);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int r;
    vectors     = 0;
    miscompares = 0;
    rst   = 0;
    tick  = 0;
    load  = 0;
    start = 0;
    stop  = 0;
    set_mt = 0;
    set_mo = 0;
    set_st = 0;
    set_so = 0;
    model_reset();
    repeat (2) @(posedge in_clk);
    #1;
    check_all();
    @(negedge in_clk);
    rst = 1;

    // 00:03 down to expiry, alarm for AT ticks
    do_load(0, 0, 0, 3);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      idle_n(1);
    end
    for (int i = 0; i < AT; i++) begin
      idle_n(1);
      step(0, 0, 0, 1);
    end
    idle_n(1);

    // full borrow chain, then reload in RUN
    do_load(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    do_load(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // stop with tick -> pause, no decrement
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // expire then stop silences the alarm
    do_load(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle_n(1);

    // bad load, start at 00:00
    do_load(0, 0, 6, 0);
    do_load(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 12, 0, 0);

    // async reset mid-run at 05:27
    do_load(0, 5, 2, 8);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    #2;
    rst = 0;
    #1;
    model_reset();
    check_all();
    @(negedge in_clk);
    rst = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) step(0, 0, 0, 1);
      else if (r < 60) step(0, 0, 1, 0);
      else if (r < 66) step(0, 1, 0, 0);
      else if (r < 70) step(0, 1, 0, 1);
      else if (r < 76)
        do_load(0, 4'($urandom_range(0, 1)),
                4'($urandom_range(0, 1)),
                4'($urandom_range(0, 9)));
      else if (r < 80)
        step(1, 0, 0, 1,
             4'($urandom_range(0, 7)),
             4'($urandom_range(0, 11)),
             4'($urandom_range(0, 7)),
             4'($urandom_range(0, 11)));
      else idle_n(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnt_down_timer.md
# cnt_down_timer

Countdown timer for the digital clock: the down-counting counterpart of the seconds/minutes up-counters. It holds a BCD mm:ss value, decrements it once per enabled tick, and raises a one-cycle `done` pulse plus a timed `alarm` level at 00:00. It sits beside the clock counters, takes the same 1 Hz tick, and drives the same 4-bit BCD digit buses to the display path.

## Interface
- `ALARM_TICKS`, default 10: number of ticks `alarm` stays high after expiry (1..255).
- `in_clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle count enable (1 Hz strobe), synchronous to `in_clk`.
- `load` input 1: load preset digits.
- `start` input 1: begin or resume counting.
- `stop` input 1: pause counting, or silence the alarm.
- `set_mt`, `set_mo`, `set_st`, `set_so` input 4 each: preset minutes tens/ones, seconds tens/ones (BCD).
- `min_t`, `min_o`, `sec_t`, `sec_o` output 4 each: current count digits (BCD).
- `running` output 1: high in RUN.
- `done` output 1: one-cycle pulse on reaching 00:00.
- `alarm` output 1: high in EXPIRED.
- `load_err` output 1: one-cycle pulse when a load is rejected.

## Operation
- Reset: all digits 0, state IDLE; `running`, `done`, `alarm`, `load_err` are 0; alarm tick counter is 0.
- Digit ranges: `min_t`/`sec_t` 0..5, `min_o`/`sec_o` 0..9. A load with any digit out of range is ignored; digits and state are unchanged and `load_err` pulses.
- Decrement is a BCD borrow chain. `sec_o` 0→9 borrows, `sec_t` 0→5 borrows, `min_o` 0→9 borrows, `min_t` 0→5. Decrement is never applied at 00:00.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Input priority per cycle: `load` > `stop` > `start` > `tick`.
- IDLE:
  - valid `load` → digits = presets, stay IDLE.
  - `start` with count ≠ 00:00 → RUN.
  - `start` at 00:00 is ignored.
- RUN:
  - `tick` → decrement.
  - If the result is 00:00 → EXPIRED, `done` = 1 for that cycle.
  - `stop` → PAUSE, with no decrement even if `tick` is also high.
  - valid `load` → digits = presets, go to IDLE.
- PAUSE:
  - `start` → RUN.
  - valid `load` → IDLE.
  - `tick` is ignored.
- EXPIRED:
  - `alarm` = 1 and each `tick` increments the alarm counter.
  - On the `ALARM_TICKS`-th tick → IDLE and the counter clears.
  - `stop` → IDLE immediately.
  - valid `load` → IDLE with presets.
  - `start` is ignored.
- An invalid `load` in any state has no effect on state; lower-priority inputs in the same cycle are still evaluated.

## Timing
- All outputs are registered.
- Inputs sampled at edge N take effect on the outputs after edge N (one-cycle latency).
- `done` asserts in the same cycle the digits first read 0000/0000. `alarm` rises in that cycle too.
- `alarm` falls on the cycle after the terminating tick, `stop`, or `load` is sampled.
- `running` follows the state register with no extra delay.
- Reset asserted mid-count clears everything asynchronously. After release, the block stays in IDLE until `start`.
- `tick` held high for several cycles decrements once per cycle. The bench drives single-cycle strobes only.

## Structure
- Package `timer_pkg`:
  - state enum (IDLE, RUN, PAUSE, EXPIRED).
  - 4-bit BCD digit type.
  - constants `TENS_MAX` = 5 and `ONES_MAX` = 9.
- Sub-module `bcd_dec_digit`:
  - parameter `MAX`.
  - inputs: digit, dec enable, borrow in.
  - outputs: next digit, borrow out.
  - four instances chained; the top-level FSM owns the registers.

## Test plan
- Load 00:03, start, 3 ticks → digits 0003→0002→0001→0000. `done` pulses once on the third tick's next cycle, `alarm` = 1.
- Load 10:00, start, 1 tick → 09:59 (full borrow chain). Load 00:10, 1 tick → 00:09.
- RUN with `stop` and `tick` in the same cycle → PAUSE, no decrement. `start` then tick → decrement resumes.
- Expire with `ALARM_TICKS` = 3 → `alarm` high for exactly 3 ticks, then IDLE. A second run with `stop` during EXPIRED → `alarm` drops next cycle.
- Load with `set_st` = 6 → `load_err` pulse, digits unchanged. `start` at 00:00 → stays IDLE, `running` = 0.
- Assert `rst` low mid-RUN at 05:27 → digits 0, IDLE immediately. After release, ticks cause no change.
